// File: rtl/cpu_datapath_if.sv
// Control strobes and observable register state for cpu_datapath.
// The sequencer drives through master; the datapath implements slave.
interface cpu_datapath_if #(parameter int WIDTH = 32);
  logic [15:0]        Rin;
  logic [15:0]        Rout;
  logic               HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin;
  logic               HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
  logic               IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV;
  logic               Read;
  logic [WIDTH-1:0]   Mdatain;

  logic [WIDTH-1:0]   R [16];
  logic [WIDTH-1:0]   HI, LO, PC_out, IR, MAR, Y;
  logic [2*WIDTH-1:0] Z;
  logic [WIDTH-1:0]   BusMuxOut_signal;

  modport master (
    output Rin, Rout,
    output HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
    output HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
    output IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
    output Read, Mdatain,
    input  R, HI, LO, PC_out, IR, MAR, Y, Z, BusMuxOut_signal
  );

  modport slave (
    input  Rin, Rout,
    input  HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
    input  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
    input  IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
    input  Read, Mdatain,
    output R, HI, LO, PC_out, IR, MAR, Y, Z, BusMuxOut_signal
  );
endinterface

// File: rtl/cpu_datapath.sv
// Bus-based CPU datapath: register file, special registers, shared bus mux and ALU.
// Define MULDIV_EN to build the signed multiplier/divider; otherwise MUL/DIV yield zero.
module cpu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           clear,
  cpu_datapath_if.slave  dp
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0]   gpr [16];
  logic [WIDTH-1:0]   hi, lo, pc, ir, mar, mdr, y;
  logic [2*WIDTH-1:0] z;

  logic [WIDTH-1:0]   bus_val;
  logic [WIDTH-1:0]   c_sext;
  logic [2*WIDTH-1:0] z_next;

  assign c_sext = {{(WIDTH-19){ir[18]}}, ir[18:0]};

  // Lowest-numbered GPR wins, then the special sources in fixed order
  always_comb begin
    bus_val = '0;
    if (|dp.Rout) begin
      for (int i = 15; i >= 0; i--) begin
        if (dp.Rout[i]) bus_val = gpr[i];
      end
    end
    else if (dp.HIout)     bus_val = hi;
    else if (dp.LOout)     bus_val = lo;
    else if (dp.Zhighout)  bus_val = z[2*WIDTH-1:WIDTH];
    else if (dp.Zlowout)   bus_val = z[WIDTH-1:0];
    else if (dp.PCout)     bus_val = pc;
    else if (dp.MDRout)    bus_val = mdr;
    else if (dp.InPortout) bus_val = '0;
    else if (dp.Cout)      bus_val = c_sext;
  end

  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [SW-1:0]      sh;
  logic [2*WIDTH-1:0] rot_r, rot_l;

  assign alu_a = y;
  assign alu_b = bus_val;
  assign sh    = alu_b[SW-1:0];
  assign rot_r = {alu_a, alu_a} >> sh;
  assign rot_l = {alu_a, alu_a} << sh;

`ifdef MULDIV_EN
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quot, rem;
  logic                      div_ovf;

  assign prod    = $signed({{WIDTH{alu_a[WIDTH-1]}}, alu_a}) *
                   $signed({{WIDTH{alu_b[WIDTH-1]}}, alu_b});
  assign div_ovf = (alu_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&alu_b);

  // Zero divisor and the single overflowing case are handled before the divider sees them
  always_comb begin
    quot = '0;
    rem  = '0;
    if (alu_b == '0) begin
      rem = $signed(alu_a);
    end
    else if (div_ovf) begin
      quot = $signed(alu_a);
    end
    else begin
      quot = $signed(alu_a) / $signed(alu_b);
      rem  = $signed(alu_a) % $signed(alu_b);
    end
  end
`endif

  always_comb begin
    z_next = '0;
    if      (dp.IncPC) z_next[WIDTH-1:0] = alu_b + 1'b1;
    else if (dp.ADD)   z_next[WIDTH-1:0] = alu_a + alu_b;
    else if (dp.SUB)   z_next[WIDTH-1:0] = alu_a - alu_b;
    else if (dp.AND)   z_next[WIDTH-1:0] = alu_a & alu_b;
    else if (dp.OR)    z_next[WIDTH-1:0] = alu_a | alu_b;
    else if (dp.SHR)   z_next[WIDTH-1:0] = alu_a >> sh;
    else if (dp.SHRA)  z_next[WIDTH-1:0] = WIDTH'($signed(alu_a) >>> sh);
    else if (dp.SHL)   z_next[WIDTH-1:0] = alu_a << sh;
    else if (dp.ROR)   z_next[WIDTH-1:0] = rot_r[WIDTH-1:0];
    else if (dp.ROL)   z_next[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
    else if (dp.NEG)   z_next[WIDTH-1:0] = -alu_b;
    else if (dp.NOT)   z_next[WIDTH-1:0] = ~alu_b;
`ifdef MULDIV_EN
    else if (dp.MUL)   z_next = prod;
    else if (dp.DIV)   z_next = {rem, quot};
`else
    else if (dp.MUL)   z_next = '0;
    else if (dp.DIV)   z_next = '0;
`endif
  end

  // Clear wins over every load enable; a register with both in and out set reloads its own value
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
      hi  <= '0;
      lo  <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      z   <= '0;
    end
    else begin
      for (int i = 0; i < 16; i++) begin
        if (dp.Rin[i]) gpr[i] <= bus_val;
      end
      if (dp.HIin)  hi  <= bus_val;
      if (dp.LOin)  lo  <= bus_val;
      if (dp.PCin)  pc  <= bus_val;
      if (dp.IRin)  ir  <= bus_val;
      if (dp.MARin) mar <= bus_val;
      if (dp.Yin)   y   <= bus_val;
      if (dp.MDRin) mdr <= dp.Read ? dp.Mdatain : bus_val;
      if (dp.Zin)   z   <= z_next;
    end
  end

  assign dp.R                = gpr;
  assign dp.HI               = hi;
  assign dp.LO               = lo;
  assign dp.PC_out           = pc;
  assign dp.IR               = ir;
  assign dp.MAR              = mar;
  assign dp.Y                = y;
  assign dp.Z                = z;
  assign dp.BusMuxOut_signal = bus_val;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed microstep sequences with literal
// expectations plus randomized control strobes checked every cycle against a behavioural model.
module tb_cpu_datapath;
  localparam int WIDTH = 32;

  localparam logic [7:0] L_HI = 8'h01, L_LO = 8'h02, L_PC = 8'h04, L_IR = 8'h08;
  localparam logic [7:0] L_Y  = 8'h10, L_Z  = 8'h20, L_MAR = 8'h40, L_MDR = 8'h80;
  localparam logic [7:0] O_HI = 8'h01, O_LO = 8'h02, O_ZH = 8'h04, O_ZL = 8'h08;
  localparam logic [7:0] O_PC = 8'h10, O_MDR = 8'h20, O_IN = 8'h40, O_C = 8'h80;
  localparam logic [13:0] OP_INC = 14'h0001, OP_ADD = 14'h0002, OP_SUB = 14'h0004;
  localparam logic [13:0] OP_AND = 14'h0008, OP_OR = 14'h0010, OP_SHR = 14'h0020;
  localparam logic [13:0] OP_SHRA = 14'h0040, OP_SHL = 14'h0080, OP_ROR = 14'h0100;
  localparam logic [13:0] OP_ROL = 14'h0200, OP_NEG = 14'h0400, OP_NOT = 14'h0800;
  localparam logic [13:0] OP_MUL = 14'h1000, OP_DIV = 14'h2000;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] r_in, r_out;
  logic [7:0]  ld_en, out_sel;
  logic [13:0] ops;
  logic        rd;
  logic [31:0] mdata;

  cpu_datapath_if #(.WIDTH(WIDTH)) dp_if ();

  cpu_datapath #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .clear (clear),
    .dp    (dp_if)
  );

  assign dp_if.Rin       = r_in;
  assign dp_if.Rout      = r_out;
  assign dp_if.HIin      = ld_en[0];
  assign dp_if.LOin      = ld_en[1];
  assign dp_if.PCin      = ld_en[2];
  assign dp_if.IRin      = ld_en[3];
  assign dp_if.Yin       = ld_en[4];
  assign dp_if.Zin       = ld_en[5];
  assign dp_if.MARin     = ld_en[6];
  assign dp_if.MDRin     = ld_en[7];
  assign dp_if.HIout     = out_sel[0];
  assign dp_if.LOout     = out_sel[1];
  assign dp_if.Zhighout  = out_sel[2];
  assign dp_if.Zlowout   = out_sel[3];
  assign dp_if.PCout     = out_sel[4];
  assign dp_if.MDRout    = out_sel[5];
  assign dp_if.InPortout = out_sel[6];
  assign dp_if.Cout      = out_sel[7];
  assign dp_if.IncPC     = ops[0];
  assign dp_if.ADD       = ops[1];
  assign dp_if.SUB       = ops[2];
  assign dp_if.AND       = ops[3];
  assign dp_if.OR        = ops[4];
  assign dp_if.SHR       = ops[5];
  assign dp_if.SHRA      = ops[6];
  assign dp_if.SHL       = ops[7];
  assign dp_if.ROR       = ops[8];
  assign dp_if.ROL       = ops[9];
  assign dp_if.NEG       = ops[10];
  assign dp_if.NOT       = ops[11];
  assign dp_if.MUL       = ops[12];
  assign dp_if.DIV       = ops[13];
  assign dp_if.Read      = rd;
  assign dp_if.Mdatain   = mdata;

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y;
  logic [63:0] m_z;
  bit          model_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // What the bus must carry given model register contents and the current selects
  function automatic logic [31:0] model_bus();
    logic [31:0] src [8];
    for (int i = 0; i < 16; i++) if (r_out[i]) return m_r[i];
    src[0] = m_hi;
    src[1] = m_lo;
    src[2] = m_z[63:32];
    src[3] = m_z[31:0];
    src[4] = m_pc;
    src[5] = m_mdr;
    src[6] = 32'h0;
    src[7] = {{13{m_ir[18]}}, m_ir[18:0]};
    for (int j = 0; j < 8; j++) if (out_sel[j]) return src[j];
    return 32'h0;
  endfunction

  function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b, input logic [13:0] op);
    int          sel = -1;
    int          s   = int'(b[4:0]);
    logic [31:0] t   = a;
    longint      pa, pb, q, r;
    for (int i = 13; i >= 0; i--) if (op[i]) sel = i;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    case (sel)
      0:  return {32'h0, b + 32'd1};
      1:  return {32'h0, a + b};
      2:  return {32'h0, a - b};
      3:  return {32'h0, a & b};
      4:  return {32'h0, a | b};
      5:  return {32'h0, a >> s};
      6:  begin
            for (int k = 0; k < s; k++) t = {t[31], t[31:1]};
            return {32'h0, t};
          end
      7:  return {32'h0, a << s};
      8:  begin
            for (int k = 0; k < s; k++) t = {t[0], t[31:1]};
            return {32'h0, t};
          end
      9:  begin
            for (int k = 0; k < s; k++) t = {t[30:0], t[31]};
            return {32'h0, t};
          end
      10: return {32'h0, 32'h0 - b};
      11: return {32'h0, ~b};
`ifdef MULDIV_EN
      12: return 64'(pa * pb);
      13: begin
            if (pb == 0) return {a, 32'h0};
            q = pa / pb;
            r = pa % pb;
            return {r[31:0], q[31:0]};
          end
`endif
      default: return 64'h0;
    endcase
  endfunction

  // Reference model advances on the same edge as the DUT using the strobes held during the cycle
  always @(posedge clock) begin
    logic [31:0] b;
    logic [63:0] zn;
    b  = model_bus();
    zn = model_alu(m_y, b, ops);
    if (clear) begin
      for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
      m_hi = 0; m_lo = 0; m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_z = 0;
      model_valid = 1'b1;
    end
    else begin
      for (int i = 0; i < 16; i++) if (r_in[i]) m_r[i] = b;
      if (ld_en[0]) m_hi  = b;
      if (ld_en[1]) m_lo  = b;
      if (ld_en[2]) m_pc  = b;
      if (ld_en[3]) m_ir  = b;
      if (ld_en[4]) m_y   = b;
      if (ld_en[5]) m_z   = zn;
      if (ld_en[6]) m_mar = b;
      if (ld_en[7]) m_mdr = rd ? mdata : b;
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      for (int i = 0; i < 16; i++) checkOutput($sformatf("R%0d", i), {32'h0, dp_if.R[i]}, {32'h0, m_r[i]});
      checkOutput("HI",  {32'h0, dp_if.HI},     {32'h0, m_hi});
      checkOutput("LO",  {32'h0, dp_if.LO},     {32'h0, m_lo});
      checkOutput("PC",  {32'h0, dp_if.PC_out}, {32'h0, m_pc});
      checkOutput("IR",  {32'h0, dp_if.IR},     {32'h0, m_ir});
      checkOutput("MAR", {32'h0, dp_if.MAR},    {32'h0, m_mar});
      checkOutput("Y",   {32'h0, dp_if.Y},      {32'h0, m_y});
      checkOutput("Z",   dp_if.Z,               m_z);
      checkOutput("bus", {32'h0, dp_if.BusMuxOut_signal}, {32'h0, model_bus()});
    end
  end

  task automatic drive(input logic [15:0] rin_v, input logic [15:0] rout_v, input logic [7:0] ld_v,
                       input logic [7:0] out_v, input logic [13:0] op_v, input logic rd_v,
                       input logic [31:0] md_v);
    r_in    = rin_v;
    r_out   = rout_v;
    ld_en   = ld_v;
    out_sel = out_v;
    ops     = op_v;
    rd      = rd_v;
    mdata   = md_v;
  endtask

  task automatic applyStimulus(input logic [15:0] rin_v, input logic [15:0] rout_v, input logic [7:0] ld_v,
                               input logic [7:0] out_v, input logic [13:0] op_v, input logic rd_v,
                               input logic [31:0] md_v);
    drive(rin_v, rout_v, ld_v, out_v, op_v, rd_v, md_v);
    @(posedge clock);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    applyStimulus(16'h0, 16'h0, L_MDR, 8'h0, 14'h0, 1'b1, v);
  endtask

  task automatic alu_step(input logic [13:0] op, input logic [63:0] expected, input string name);
    applyStimulus(16'h0, 16'h0, L_Z, O_MDR, op, 1'b0, 32'h0);
    checkOutput(name, dp_if.Z, expected);
  endtask

  initial begin
    clear = 1'b1;
    drive(16'h0, 16'h0, 8'h0, 8'h0, 14'h0, 1'b0, 32'h0);
    @(posedge clock);
    #1;
    clear = 1'b0;

    // Model pins: literal results straight from the arithmetic rules
    checkOutput("model_sub",  model_alu(32'h34, 32'h45, OP_SUB),      64'h0000_0000_FFFF_FFEF);
    checkOutput("model_shra", model_alu(32'h8000_0001, 32'd1, OP_SHRA), 64'h0000_0000_C000_0000);
    checkOutput("model_ror",  model_alu(32'h8000_0001, 32'd1, OP_ROR),  64'h0000_0000_C000_0000);
    checkOutput("model_prio", model_alu(32'h5, 32'h3, OP_ADD | OP_SUB), 64'h0000_0000_0000_0008);
    checkOutput("model_none", model_alu(32'h5, 32'h3, 14'h0),           64'h0);

    // Arbitrary loads, then clear with every enable still asserted
    load_mdr(32'hDEAD_BEEF);
    applyStimulus(16'hFFFF, 16'h0, L_HI | L_LO | L_PC | L_IR | L_Y | L_MAR | L_Z, O_MDR, OP_ADD, 1'b0, 32'h0);
    clear = 1'b1;
    applyStimulus(16'hFFFF, 16'h0, 8'hFF, O_MDR, OP_ADD, 1'b1, 32'h1234);
    clear = 1'b0;
    checkOutput("rst_R0",  {32'h0, dp_if.R[0]},  64'h0);
    checkOutput("rst_R15", {32'h0, dp_if.R[15]}, 64'h0);
    checkOutput("rst_HI",  {32'h0, dp_if.HI},    64'h0);
    checkOutput("rst_PC",  {32'h0, dp_if.PC_out}, 64'h0);
    checkOutput("rst_Y",   {32'h0, dp_if.Y},     64'h0);
    checkOutput("rst_Z",   dp_if.Z,              64'h0);

    load_mdr(32'h34);
    applyStimulus(16'h0020, 16'h0, 8'h0, O_MDR, 14'h0, 1'b0, 32'h0);
    checkOutput("ld_R5", {32'h0, dp_if.R[5]}, 64'h34);
    load_mdr(32'h45);
    applyStimulus(16'h0040, 16'h0, 8'h0, O_MDR, 14'h0, 1'b0, 32'h0);
    checkOutput("ld_R6", {32'h0, dp_if.R[6]}, 64'h45);
    load_mdr(32'h67);
    applyStimulus(16'h0004, 16'h0, 8'h0, O_MDR, 14'h0, 1'b0, 32'h0);
    checkOutput("ld_R2", {32'h0, dp_if.R[2]}, 64'h67);

    // SUB R2,R5,R6
    applyStimulus(16'h0, 16'h0020, L_Y, 8'h0, 14'h0, 1'b0, 32'h0);
    checkOutput("sub_Y", {32'h0, dp_if.Y}, 64'h34);
    applyStimulus(16'h0, 16'h0040, L_Z, 8'h0, OP_SUB, 1'b0, 32'h0);
    checkOutput("sub_Z", dp_if.Z, 64'h0000_0000_FFFF_FFEF);
    applyStimulus(16'h0004, 16'h0, 8'h0, O_ZL, 14'h0, 1'b0, 32'h0);
    checkOutput("sub_R2", {32'h0, dp_if.R[2]}, 64'hFFFF_FFEF);

    // GPR priority over special sources, and an idle bus
    drive(16'h0, 16'h0060, 8'h0, O_HI, 14'h0, 1'b0, 32'h0);
    #1;
    checkOutput("bus_prio", {32'h0, dp_if.BusMuxOut_signal}, 64'h34);
    drive(16'h0, 16'h0, 8'h0, 8'h0, 14'h0, 1'b0, 32'h0);
    #1;
    checkOutput("bus_idle", {32'h0, dp_if.BusMuxOut_signal}, 64'h0);

    // Instruction fetch
    applyStimulus(16'h0, 16'h0, L_MAR | L_Z, O_PC, OP_INC, 1'b0, 32'h0);
    checkOutput("fetch_MAR", {32'h0, dp_if.MAR}, 64'h0);
    checkOutput("fetch_Z",   dp_if.Z,            64'h1);
    applyStimulus(16'h0, 16'h0, L_PC | L_MDR, O_ZL, 14'h0, 1'b1, 32'h112B_0000);
    checkOutput("fetch_PC", {32'h0, dp_if.PC_out}, 64'h1);
    drive(16'h0, 16'h0, L_IR, O_MDR, 14'h0, 1'b0, 32'h0);
    #1;
    checkOutput("fetch_MDR_bus", {32'h0, dp_if.BusMuxOut_signal}, 64'h112B_0000);
    @(posedge clock);
    #1;
    checkOutput("fetch_IR", {32'h0, dp_if.IR}, 64'h112B_0000);

    drive(16'h0, 16'h0, 8'h0, O_C, 14'h0, 1'b0, 32'h0);
    #1;
    checkOutput("c_pos", {32'h0, dp_if.BusMuxOut_signal}, 64'h0003_0000);
    load_mdr(32'h0007_FFFF);
    applyStimulus(16'h0, 16'h0, L_IR, O_MDR, 14'h0, 1'b0, 32'h0);
    drive(16'h0, 16'h0, 8'h0, O_C, 14'h0, 1'b0, 32'h0);
    #1;
    checkOutput("c_neg", {32'h0, dp_if.BusMuxOut_signal}, 64'hFFFF_FFFF);

    // Shifts and rotates of Y = 0x80000001 by 1
    load_mdr(32'h8000_0001);
    applyStimulus(16'h0, 16'h0, L_Y, O_MDR, 14'h0, 1'b0, 32'h0);
    load_mdr(32'h1);
    alu_step(OP_SHR,  64'h4000_0000, "shr");
    alu_step(OP_SHRA, 64'hC000_0000, "shra");
    alu_step(OP_SHL,  64'h0000_0002, "shl");
    alu_step(OP_ROR,  64'hC000_0000, "ror");
    alu_step(OP_ROL,  64'h0000_0003, "rol");
    load_mdr(32'h0F);
    alu_step(OP_NOT,  64'hFFFF_FFF0, "not");

    load_mdr(32'hFFFF_FFFE);
    applyStimulus(16'h0, 16'h0, L_Y, O_MDR, 14'h0, 1'b0, 32'h0);
    load_mdr(32'h3);
`ifdef MULDIV_EN
    alu_step(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFA, "mul");
`else
    alu_step(OP_MUL, 64'h0, "mul_off");
`endif
    load_mdr(32'h7);
    applyStimulus(16'h0, 16'h0, L_Y, O_MDR, 14'h0, 1'b0, 32'h0);
    load_mdr(32'h2);
`ifdef MULDIV_EN
    alu_step(OP_DIV, 64'h0000_0001_0000_0003, "div");
`else
    alu_step(OP_DIV, 64'h0, "div_off");
`endif
    load_mdr(32'h0);
`ifdef MULDIV_EN
    alu_step(OP_DIV, 64'h0000_0007_0000_0000, "div_zero");
`else
    alu_step(OP_DIV, 64'h0, "div_zero_off");
`endif

    // Randomized strobes, including overlapping selects and occasional clears
    for (int n = 0; n < 3000; n++) begin
      clear = ($urandom_range(0, 99) == 0);
      applyStimulus(16'($urandom & $urandom & $urandom),
                    16'($urandom & $urandom & $urandom & $urandom),
                    8'($urandom & $urandom),
                    8'($urandom & $urandom & $urandom),
                    14'($urandom & $urandom & $urandom),
                    1'($urandom),
                    ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
    end
    clear = 1'b0;
    drive(16'h0, 16'h0, 8'h0, 8'h0, 14'h0, 1'b0, 32'h0);
    @(negedge clock);
    @(posedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Bus-based single-cycle-per-microstep CPU datapath.
- Contains sixteen 32-bit GPRs, HI, LO, PC, IR, MAR, MDR, Y, a 64-bit Z, and a shared 32-bit bus.
- Includes an ALU with A = Y and B = bus.
- An external control sequencer (testbench or control unit) drives all register-enable, bus-select and ALU-op strobes each clock.

Parameters:
- WIDTH, 32, datapath word width; Z is 2*WIDTH.

Ports:
- clock  in  1  system clock; all registers update on rising edge.
- clear  in  1  synchronous active-high reset.
- R0in..R15in  in  1 each  load GPR Rn from bus.
- HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin  in  1 each  register load enables.
- R0out..R15out  in  1 each  drive GPR Rn onto bus.
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout  in  1 each  bus source selects.
- IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV  in  1 each  ALU op strobes.
- Read  in  1  MDR input mux: 1 = Mdatain, 0 = bus.
- Mdatain  in  32  memory read data.
- R0..R15  out  32 each  GPR contents.
- HI, LO, PC_out, IR, MAR, Y  out  32 each  register contents.
- Z  out  64  Z register.
- BusMuxOut_signal  out  32  current bus value.

Behaviour:
- Reset: clear=1 at a rising edge sets every register (R0..R15, HI, LO, PC, IR, MAR, MDR, Y, Z) to 0. Clear overrides all load enables.
- Register loads: each register with its enable high captures its source on the rising edge; otherwise it holds.
  - GPRs, HI, LO, PC, IR, MAR, Y load from the bus.
  - MDR loads Mdatain when Read=1, else the bus.
  - Z loads the 64-bit ALU result when Zin=1.
- Bus: combinational mux. Fixed priority when several out-selects are high: R0..R15, HI, LO, Zhigh (Z[63:32]), Zlow (Z[31:0]), PC, MDR, InPort, C.
  - No select active -> bus = 0.
  - InPort source is constant 0 (no input port in this block).
  - C source = IR[18:0] sign-extended to 32 bits.
- Register-to-bus is same-cycle combinational: a value loaded at edge k is visible on the bus during cycle k+1.
- ALU: combinational, A = Y, B = bus. Result Z64; Z64[63:32] = 0 unless stated.
  - IncPC: low = B + 1.
  - ADD: A + B. SUB: A - B, two's complement, mod 2^32 (0x34 - 0x45 = 0xFFFFFFEF).
  - AND, OR: bitwise.
  - SHR: logical right shift of A by B[4:0]. SHRA: arithmetic right. SHL: left. ROR/ROL: rotate by B[4:0]. Shift amount 0 -> A unchanged.
  - NEG: -B. NOT: ~B.
  - MUL: signed A*B, full 64-bit into Z64.
  - DIV: signed A/B, truncating toward zero. Z64[31:0] = quotient, Z64[63:32] = remainder (sign of dividend). B = 0 -> quotient 0, remainder A.
- Op priority when several strobes are high: IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV. No strobe -> Z64 = 0.
- No hardwired-zero GPR; R0 is an ordinary register.
- Simultaneous load and out on the same register: bus shows the old value; the register captures the bus (holds effectively).

Optional Feature:
- MULDIV_EN defined: MUL and DIV are implemented as specified.
- MULDIV_EN undefined: MUL and DIV strobes yield Z64 = 0 and no multiplier/divider logic is synthesized. All other ops are unchanged.

Test Plan:
- Reset: clear=1 for one edge after arbitrary loads -> all R*, HI, LO, PC_out, IR, MAR, Y = 0, Z = 0.
- Load via MDR: Mdatain=0x34, Read=1, MDRin=1, then MDRout=1, R5in=1 -> R5 = 0x34. Repeat 0x45 -> R6, 0x67 -> R2.
- SUB R2,R5,R6:
  - R5out, Yin -> Y = 0x34.
  - R6out, SUB, Zin -> Z[31:0] = 0xFFFFFFEF.
  - Zlowout, R2in -> R2 = 0xFFFFFFEF.
- Fetch:
  - PC=0; PCout, MARin, IncPC, Zin -> MAR = 0, Z = 1.
  - Zlowout, PCin, Read=1, MDRin=1, Mdatain=0x112B0000 -> PC = 1, MDR = 0x112B0000.
  - MDRout, IRin -> IR = 0x112B0000.
- MUL/DIV (MULDIV_EN): Y = 0xFFFFFFFE, B = 3 -> MUL gives Z = 0xFFFFFFFF_FFFFFFFA. Y = 7, B = 2 -> DIV gives Z = {1, 3}. B = 0 -> Z = {7, 0}.
- Shifts: Y = 0x80000001, B = 1.
  - SHR -> 0x40000000.
  - SHRA -> 0xC0000000.
  - SHL -> 0x00000002.
  - ROR -> 0xC0000000.
  - ROL -> 0x00000003.
  - NOT of B = 0x0F -> 0xFFFFFFF0.
